// File: rtl/ball_feed_scheduler_pkg.sv
// Shared definitions for the ball feed scheduler and anything that decodes
// its grants (detector blocks, checkers).
//   - colour codes GC/BC/RC as carried on ball_col (11 is never used)
//   - bit positions of each chute inside req/gnt
//   - one-hot <-> colour conversion helpers
//   - sched_state_t: pointer and history, exported for observation
package ball_feed_scheduler_pkg;

  // Bit positions inside req/gnt.
  localparam int G_IDX = 0;
  localparam int B_IDX = 1;
  localparam int R_IDX = 2;

  localparam logic [7:0] DET_CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    GC = 2'b00,
    BC = 2'b01,
    RC = 2'b10
  } colour_t;

  typedef struct packed {
    colour_t ptr;     // last granted colour (round-robin pointer)
    logic    h0_vld;
    colour_t h0;      // newest granted colour
    logic    h1_vld;
    colour_t h1;      // the grant before h0
  } sched_state_t;

  function automatic colour_t onehot_to_col(input logic [2:0] oh);
    colour_t c;
    c = GC;
    if (oh[B_IDX]) c = BC;
    if (oh[R_IDX]) c = RC;
    return c;
  endfunction

  function automatic logic [2:0] col_to_onehot(input colour_t c);
    logic [2:0] oh;
    oh = 3'b000;
    case (c)
      GC:      oh[G_IDX] = 1'b1;
      BC:      oh[B_IDX] = 1'b1;
      RC:      oh[R_IDX] = 1'b1;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // G -> B -> R -> G
  function automatic colour_t next_col(input colour_t c);
    colour_t n;
    case (c)
      GC:      n = BC;
      BC:      n = RC;
      default: n = GC;
    endcase
    return n;
  endfunction

  // For two distinct colours, codes 0+1+2 = 3, so the third one is
  // 3 - a - b. Meaningless when a == b; callers must qualify.
  function automatic colour_t missing_col(input colour_t a, input colour_t b);
    return colour_t'(2'd3 - 2'(a) - 2'(b));
  endfunction

  function automatic logic is_perm(input colour_t a, input colour_t b, input colour_t c);
    return (a != b) && (b != c) && (a != c);
  endfunction

endpackage

// File: rtl/ball_feed_scheduler_if.sv
// Bus between the chute controller (master) and the scheduler (slave).
//
// Handshake: req is a level request per chute with no ready/ack. A grant
// is a single-cycle one-hot pulse on gnt; ball_vld is high exactly in the
// cycles where gnt is non-zero and qualifies ball_col and det. ball_col
// holds its last value while ball_vld is low. A chute that keeps req high
// is regranted at most every other cycle.
//
// Signals:
//   en       master->slave  scheduling enable
//   req[2:0] master->slave  chute requests (bit0 G, bit1 B, bit2 R)
//   clr_cnt  master->slave  synchronous clear of det_cnt
//   gnt[2:0] slave->master  registered one-hot grant
//   ball_vld slave->master  grant valid
//   ball_col slave->master  colour code of the granted ball
//   det      slave->master  granted ball completes a G/B/R permutation
//   det_cnt  slave->master  saturating detection count
//   dbg      slave->master  pointer and history state
interface ball_feed_scheduler_if;
  import ball_feed_scheduler_pkg::*;

  logic         en;
  logic [2:0]   req;
  logic         clr_cnt;
  logic [2:0]   gnt;
  logic         ball_vld;
  logic [1:0]   ball_col;
  logic         det;
  logic [7:0]   det_cnt;
  sched_state_t dbg;

  modport master (
    output en, req, clr_cnt,
    input  gnt, ball_vld, ball_col, det, det_cnt, dbg
  );

  modport slave (
    input  en, req, clr_cnt,
    output gnt, ball_vld, ball_col, det, det_cnt, dbg
  );

endinterface

// File: rtl/ball_feed_scheduler_rr_arb3.sv
// rr_arb3: combinational 3-way round-robin search.
// Ports:
//   req[2:0]  in   already-masked (eligible) requests, G/B/R bit order
//   ptr       in   last granted colour; search order ptr+1, ptr+2, ptr
//   gnt[2:0]  out  one-hot winner, zero when req is zero
//   any       out  at least one request present
module rr_arb3
  import ball_feed_scheduler_pkg::*;
(
  input  logic [2:0] req,
  input  colour_t    ptr,
  output logic [2:0] gnt,
  output logic       any
);

  colour_t    c1;
  colour_t    c2;
  logic [2:0] oh1;
  logic [2:0] oh2;
  logic [2:0] oh0;

  assign c1  = next_col(ptr);
  assign c2  = next_col(c1);
  assign oh1 = col_to_onehot(c1);
  assign oh2 = col_to_onehot(c2);
  assign oh0 = col_to_onehot(ptr);
  assign any = |req;

  always_comb begin
    gnt = 3'b000;
    if (|(req & oh1)) begin
      gnt = oh1;
    end else if (|(req & oh2)) begin
      gnt = oh2;
    end else if (|(req & oh0)) begin
      gnt = oh0;
    end
  end

endmodule

// File: rtl/ball_feed_scheduler.sv
// ball_feed_scheduler: grants one ball chute per cycle and flags each ball
// that completes a G/B/R permutation with the two balls granted before it.
// Parameters:
//   MODE_FILL  1: a missing third colour is granted ahead of round-robin
//              0: pure round-robin
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  slave modport of ball_feed_scheduler_if (see that file)
module ball_feed_scheduler
  import ball_feed_scheduler_pkg::*;
#(
  parameter int MODE_FILL = 1
) (
  input logic                  clk,
  input logic                  rst,
  ball_feed_scheduler_if.slave bus
);

  logic [2:0] gnt_q;
  logic       vld_q;
  colour_t    col_q;
  logic       det_q;
  logic [7:0] cnt_q;
  colour_t    ptr_q;
  colour_t    h0_q;
  colour_t    h1_q;
  logic       h0_vld_q;
  logic       h1_vld_q;

  logic [2:0] elig;
  logic [2:0] rr_gnt;
  logic       rr_any;
  colour_t    fill_col;
  logic [2:0] fill_oh;
  logic       fill_ok;
  logic       grant;
  logic [2:0] sel_gnt;
  colour_t    new_col;
  logic       det_next;
  logic [7:0] cnt_next;

  // A chute granted this cycle sits out the next evaluation.
  assign elig = bus.req & ~gnt_q;

  rr_arb3 u_rr (
    .req (elig),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .any (rr_any)
  );

  assign fill_col = missing_col(h0_q, h1_q);
  assign fill_oh  = col_to_onehot(fill_col);
  assign fill_ok  = (MODE_FILL != 0) && h0_vld_q && h1_vld_q &&
                    (h0_q != h1_q) && (|(elig & fill_oh));

  always_comb begin
    sel_gnt = fill_ok ? fill_oh : rr_gnt;
    grant   = bus.en && rr_any;
    new_col = onehot_to_col(sel_gnt);
  end

  // Detection is decided on the grant edge so det lines up with ball_vld
  // of the ball that completes the triplet.
  always_comb begin
    det_next = grant && h0_vld_q && h1_vld_q && is_perm(new_col, h0_q, h1_q);
    if (bus.clr_cnt) begin
      cnt_next = det_next ? 8'd1 : 8'd0;
    end else if (det_next && (cnt_q != DET_CNT_MAX)) begin
      cnt_next = cnt_q + 8'd1;
    end else begin
      cnt_next = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q    <= 3'b000;
      vld_q    <= 1'b0;
      col_q    <= GC;
      det_q    <= 1'b0;
      cnt_q    <= 8'd0;
      ptr_q    <= RC;       // first search starts at G
      h0_q     <= GC;
      h1_q     <= GC;
      h0_vld_q <= 1'b0;
      h1_vld_q <= 1'b0;
    end else begin
      gnt_q <= grant ? sel_gnt : 3'b000;
      vld_q <= grant;
      det_q <= det_next;
      cnt_q <= cnt_next;
      if (grant) begin
        col_q    <= new_col;
        ptr_q    <= new_col;
        h0_q     <= new_col;
        h0_vld_q <= 1'b1;
        h1_q     <= h0_q;
        h1_vld_q <= h0_vld_q;
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ball_vld = vld_q;
  assign bus.ball_col = col_q;
  assign bus.det      = det_q;
  assign bus.det_cnt  = cnt_q;
  assign bus.dbg      = '{ptr: ptr_q, h0_vld: h0_vld_q, h0: h0_q,
                          h1_vld: h1_vld_q, h1: h1_q};

endmodule

// File: tb/tb_ball_feed_scheduler.sv
// Bench for ball_feed_scheduler: a MODE_FILL=1 and a MODE_FILL=0 instance
// share one stimulus stream; each is checked against a colour-level model
// and, in the directed parts, against hand-derived constants.
module tb_ball_feed_scheduler;
  import ball_feed_scheduler_pkg::*;

  localparam int W = 17;  // {gnt[3], vld, col[2], det, cnt[8], ptr[2]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_i = 1'b0;
  logic [2:0] req_i = 3'b000;
  logic       clr_i = 1'b0;

  always #5 clk = ~clk;

  ball_feed_scheduler_if bus_f ();
  ball_feed_scheduler_if bus_r ();

  assign bus_f.en      = en_i;
  assign bus_f.req     = req_i;
  assign bus_f.clr_cnt = clr_i;
  assign bus_r.en      = en_i;
  assign bus_r.req     = req_i;
  assign bus_r.clr_cnt = clr_i;

  ball_feed_scheduler #(.MODE_FILL(1)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));
  ball_feed_scheduler #(.MODE_FILL(0)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0 = fill, 1 = round-robin) ----
  // Colours as integers 0=G 1=B 2=R; last_gnt = -1 when nothing granted.
  int m_ptr[2], m_last[2], m_col[2], m_det[2], m_cnt[2];
  int m_hn[2], m_ho[2], m_hcnt[2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 2; m_last[m] = -1; m_col[m] = 0; m_det[m] = 0;
      m_cnt[m] = 0; m_hn[m] = 0; m_ho[m] = 0; m_hcnt[m] = 0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_step(input int m, input bit fill, input bit e,
                                     input logic [2:0] r, input bit c);
    bit el[3];
    int pick;
    logic [W-1:0] v;
    pick = -1;
    for (int k = 0; k < 3; k++) el[k] = r[k] && (m_last[m] != k);
    if (e) begin
      if (fill && m_hcnt[m] == 2 && m_hn[m] != m_ho[m]) begin
        if (el[3 - m_hn[m] - m_ho[m]]) pick = 3 - m_hn[m] - m_ho[m];
      end
      for (int k = 1; k <= 3; k++) begin
        if (pick < 0 && el[(m_ptr[m] + k) % 3]) pick = (m_ptr[m] + k) % 3;
      end
    end
    if (pick >= 0) begin
      m_det[m] = (m_hcnt[m] == 2 && pick != m_hn[m] && pick != m_ho[m] &&
                  m_hn[m] != m_ho[m]) ? 1 : 0;
      m_ho[m] = m_hn[m];
      m_hn[m] = pick;
      m_hcnt[m] = (m_hcnt[m] < 2) ? m_hcnt[m] + 1 : 2;
      m_ptr[m] = pick;
      m_col[m] = pick;
    end else begin
      m_det[m] = 0;
    end
    m_last[m] = pick;
    if (c) m_cnt[m] = m_det[m];
    else if (m_det[m] == 1 && m_cnt[m] < 255) m_cnt[m] = m_cnt[m] + 1;
    v[16:14] = (pick >= 0) ? 3'(1 << pick) : 3'b000;
    v[13]    = (pick >= 0);
    v[12:11] = 2'(m_col[m]);
    v[10]    = m_det[m][0];
    v[9:2]   = 8'(m_cnt[m]);
    v[1:0]   = 2'(m_ptr[m]);
    exp_q.push_back(v);
  endfunction

  task automatic compare_dut(input string tag, input logic [2:0] g, input logic vld,
                             input logic [1:0] col, input logic d,
                             input logic [7:0] cnt, input logic [1:0] p);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk({tag, "_gnt"}, int'(g), int'(e[16:14]));
    chk({tag, "_vld"}, int'(vld), int'(e[13]));
    chk({tag, "_col"}, int'(col), int'(e[12:11]));
    chk({tag, "_det"}, int'(d), int'(e[10]));
    chk({tag, "_cnt"}, int'(cnt), int'(e[9:2]));
    chk({tag, "_ptr"}, int'(p), int'(e[1:0]));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit e, input logic [2:0] r, input bit c);
    en_i = e; req_i = r; clr_i = c;
    @(posedge clk);
    model_step(0, 1'b1, e, r, c);
    model_step(1, 1'b0, e, r, c);
    #1;
    compare_dut("fill", bus_f.gnt, bus_f.ball_vld, bus_f.ball_col, bus_f.det,
                bus_f.det_cnt, bus_f.dbg.ptr);
    compare_dut("rr", bus_r.gnt, bus_r.ball_vld, bus_r.ball_col, bus_r.det,
                bus_r.det_cnt, bus_r.dbg.ptr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_f_gnt"}, int'(bus_f.gnt), 0);
    chk({tag, "_f_vld"}, int'(bus_f.ball_vld), 0);
    chk({tag, "_f_col"}, int'(bus_f.ball_col), 0);
    chk({tag, "_f_det"}, int'(bus_f.det), 0);
    chk({tag, "_f_cnt"}, int'(bus_f.det_cnt), 0);
    chk({tag, "_f_ptr"}, int'(bus_f.dbg.ptr), 2);
    chk({tag, "_r_gnt"}, int'(bus_r.gnt), 0);
    chk({tag, "_r_vld"}, int'(bus_r.ball_vld), 0);
    chk({tag, "_r_cnt"}, int'(bus_r.det_cnt), 0);
    chk({tag, "_r_hv"}, int'({bus_r.dbg.h0_vld, bus_r.dbg.h1_vld}), 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit         en;
    logic [2:0] req;
    bit         clr;
    logic [2:0] gnt_f;
    bit         det_f;
    int         cnt_f;
    logic [2:0] gnt_r;
    bit         det_r;
    int         cnt_r;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // req=111 from reset: G,B,R,G,B,R in both modes, four detections
    vecs[0]  = '{1, 3'b111, 0, 3'b001, 0, 0, 3'b001, 0, 0};
    vecs[1]  = '{1, 3'b111, 0, 3'b010, 0, 0, 3'b010, 0, 0};
    vecs[2]  = '{1, 3'b111, 0, 3'b100, 1, 1, 3'b100, 1, 1};
    vecs[3]  = '{1, 3'b111, 0, 3'b001, 1, 2, 3'b001, 1, 2};
    vecs[4]  = '{1, 3'b111, 0, 3'b010, 1, 3, 3'b010, 1, 3};
    vecs[5]  = '{1, 3'b111, 0, 3'b100, 1, 4, 3'b100, 1, 4};
    // grant B then G, then req=110: fill takes R (det), round-robin takes B
    vecs[6]  = '{1, 3'b010, 0, 3'b010, 0, 4, 3'b010, 0, 4};
    vecs[7]  = '{1, 3'b001, 0, 3'b001, 1, 5, 3'b001, 1, 5};
    vecs[8]  = '{1, 3'b110, 0, 3'b100, 1, 6, 3'b010, 0, 5};
    // disabled for 5 cycles with all chutes requesting
    vecs[9]  = '{0, 3'b111, 0, 3'b000, 0, 6, 3'b000, 0, 5};
    vecs[10] = '{0, 3'b111, 0, 3'b000, 0, 6, 3'b000, 0, 5};
    vecs[11] = '{0, 3'b111, 0, 3'b000, 0, 6, 3'b000, 0, 5};
    vecs[12] = '{0, 3'b111, 0, 3'b000, 0, 6, 3'b000, 0, 5};
    vecs[13] = '{0, 3'b111, 0, 3'b000, 0, 6, 3'b000, 0, 5};
    // re-enable: history/pointer survived (fill: B, rr: R, both detect)
    vecs[14] = '{1, 3'b111, 0, 3'b010, 1, 7, 3'b100, 1, 6};
    // clear while disabled, then a detection counts from zero
    vecs[15] = '{0, 3'b000, 1, 3'b000, 0, 0, 3'b000, 0, 0};
    vecs[16] = '{1, 3'b111, 0, 3'b001, 1, 1, 3'b001, 1, 1};
  end

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].en, vecs[i].req, vecs[i].clr);
      chk($sformatf("vec%0d_f_gnt", i), int'(bus_f.gnt), int'(vecs[i].gnt_f));
      chk($sformatf("vec%0d_f_det", i), int'(bus_f.det), int'(vecs[i].det_f));
      chk($sformatf("vec%0d_f_cnt", i), int'(bus_f.det_cnt), vecs[i].cnt_f);
      chk($sformatf("vec%0d_r_gnt", i), int'(bus_r.gnt), int'(vecs[i].gnt_r));
      chk($sformatf("vec%0d_r_det", i), int'(bus_r.det), int'(vecs[i].det_r));
      chk($sformatf("vec%0d_r_cnt", i), int'(bus_r.det_cnt), vecs[i].cnt_r);
    end

    // Saturation: every further grant with req=111 detects.
    for (int i = 0; i < 270; i++) step(1'b1, 3'b111, 1'b0);
    chk("sat_f_cnt", int'(bus_f.det_cnt), 255);
    chk("sat_r_cnt", int'(bus_r.det_cnt), 255);
    step(1'b1, 3'b111, 1'b1);
    chk("clr_det_f_det", int'(bus_f.det), 1);
    chk("clr_det_f_cnt", int'(bus_f.det_cnt), 1);
    chk("clr_det_r_cnt", int'(bus_r.det_cnt), 1);

    // Reset between edges while a grant is on the bus.
    chk("pre_rst_f_vld", int'(bus_f.ball_vld), 1);
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    req_i = 3'b111; en_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_f_gnt", int'(bus_f.gnt), 0);
    #2 rst = 1'b1;
    step(1'b1, 3'b111, 1'b0);
    chk("post_rst_first_gnt", int'(bus_f.gnt), 1);
    chk("post_rst_det1", int'(bus_f.det), 0);
    step(1'b1, 3'b111, 1'b0);
    chk("post_rst_det2", int'(bus_f.det), 0);
    chk("post_rst_r_det2", int'(bus_r.det), 0);
    step(1'b1, 3'b111, 1'b0);
    chk("post_rst_det3", int'(bus_f.det), 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 31) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
